// File: rtl/pmod_alert_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pmod_alert_pkg                                               |
// | Description : Shared types and helpers for the PMOD alert scheduler:       |
// |               FSM state encoding, default tick lengths and a priority      |
// |               encoder returning the highest set request index.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pmod_alert_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } alert_state_t;

   localparam int DEFAULT_TICKS_ON  = 2000000;
   localparam int DEFAULT_TICKS_OFF = 2000000;
   localparam int DEFAULT_TICKS_GAP = 30000000;

   // Upper bound on requesters handled by the priority encoder.
   localparam int MAX_REQ = 32;
   localparam int IDX_W   = 5;

   // Highest set bit index of vec; 0 when vec is empty (callers gate on |vec).
   function automatic logic [IDX_W-1:0] highest_set(input logic [MAX_REQ-1:0] vec);
      highest_set = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (vec[i]) begin
            highest_set = IDX_W'(i);
         end
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/pmod_tick_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmod_tick_timer                                              |
// | Description : Loadable down-counter that holds at zero.                    |
// | Ports       : i_clock  - clock                                             |
// |               i_reset  - synchronous active-high reset (count -> 0)        |
// |               load     - load value into the counter this edge             |
// |               value    - value to load                                     |
// |               count    - current count                                     |
// |               zero     - count == 0                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pmod_tick_timer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/pmod_alert_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmod_alert_scheduler                                         |
// | Description : Shares the PMOD buzzer among N_REQ alert requesters.         |
// |               Latches request pulses, grants the highest pending index,    |
// |               plays k+1 beeps for requester k, then holds a silent gap.    |
// | Ports       : i_clock  - clock                                             |
// |               i_reset  - synchronous active-high reset                     |
// |               i_req    - request pulses, one bit per requester             |
// |               i_mute   - forces o_buzzer low, sequencing unaffected        |
// |               o_buzzer - registered buzzer pin drive                       |
// |               o_busy   - first ON cycle through last GAP cycle             |
// |               o_grant  - one-hot requester being served                    |
// |               o_done   - pulse in last GAP cycle of a completed pattern    |
// | Config      : ALERT_PREEMPT_EN - a higher request aborts the current       |
// |               pattern during ON/OFF and jumps to a full GAP.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pmod_alert_scheduler
   import pmod_alert_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int TICKS_ON  = DEFAULT_TICKS_ON,
   parameter int TICKS_OFF = DEFAULT_TICKS_OFF,
   parameter int TICKS_GAP = DEFAULT_TICKS_GAP
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_mute,
   output logic             o_buzzer,
   output logic             o_busy,
   output logic [N_REQ-1:0] o_grant,
   output logic             o_done
);

   localparam int MAX_ON_OFF = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
   localparam int MAX_TICKS  = (MAX_ON_OFF > TICKS_GAP) ? MAX_ON_OFF : TICKS_GAP;
   localparam int TW         = $clog2(MAX_TICKS + 1);
   localparam int BW         = $clog2(N_REQ + 1);

   alert_state_t     state, state_d;
   logic [N_REQ-1:0] pending, pending_d;
   logic [N_REQ-1:0] grant, grant_d;
   logic [N_REQ-1:0] cand;
   logic [BW-1:0]    beeps, beeps_d;
   logic             aborted, aborted_d;
   logic             preempt;
   logic [MAX_REQ-1:0] cand_wide;
   logic [IDX_W-1:0] top_idx;

   logic             timer_load;
   logic [TW-1:0]    timer_value;
   logic [TW-1:0]    timer_count;
   logic [TW-1:0]    timer_next;
   logic             timer_zero;

   pmod_tick_timer #(
      .WIDTH (TW)
   ) u_timer (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .load    (timer_load),
      .value   (timer_value),
      .count   (timer_count),
      .zero    (timer_zero)
   );

`ifdef ALERT_PREEMPT_EN
   logic [N_REQ-1:0] above_mask;
   // grant is one-hot: (grant<<1)-1 covers grant and everything below it.
   assign above_mask = ~((grant << 1) - N_REQ'(1));
   assign preempt    = |(cand & above_mask);
`else
   assign preempt    = 1'b0;
`endif

   always_comb begin
      cand        = pending | i_req;
      cand_wide   = '0;
      cand_wide[N_REQ-1:0] = cand;
      top_idx     = highest_set(cand_wide);

      state_d     = state;
      grant_d     = grant;
      beeps_d     = beeps;
      aborted_d   = aborted;
      pending_d   = cand;
      timer_load  = 1'b0;
      timer_value = '0;

      case (state)
         ST_IDLE: begin
            if (|cand) begin
               state_d     = ST_ON;
               grant_d     = N_REQ'(1) << top_idx;
               beeps_d     = BW'(top_idx) + BW'(1);
               aborted_d   = 1'b0;
               // A same-cycle request for the granted index is consumed here.
               pending_d   = cand & ~grant_d;
               timer_load  = 1'b1;
               timer_value = TW'(TICKS_ON - 1);
            end
         end
         ST_ON: begin
            if (preempt) begin
               state_d     = ST_GAP;
               aborted_d   = 1'b1;
               timer_load  = 1'b1;
               timer_value = TW'(TICKS_GAP - 1);
            end else if (timer_zero) begin
               beeps_d    = beeps - BW'(1);
               timer_load = 1'b1;
               if (beeps == BW'(1)) begin
                  state_d     = ST_GAP;
                  timer_value = TW'(TICKS_GAP - 1);
               end else begin
                  state_d     = ST_OFF;
                  timer_value = TW'(TICKS_OFF - 1);
               end
            end
         end
         ST_OFF: begin
            if (preempt) begin
               state_d     = ST_GAP;
               aborted_d   = 1'b1;
               timer_load  = 1'b1;
               timer_value = TW'(TICKS_GAP - 1);
            end else if (timer_zero) begin
               state_d     = ST_ON;
               timer_load  = 1'b1;
               timer_value = TW'(TICKS_ON - 1);
            end
         end
         ST_GAP: begin
            if (timer_zero) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      // Count the timer will hold next cycle; used to register o_done so it
      // lands in the last GAP cycle rather than one cycle late.
      if (timer_load) begin
         timer_next = timer_value;
      end else if (timer_zero) begin
         timer_next = '0;
      end else begin
         timer_next = timer_count - TW'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         pending  <= '0;
         grant    <= '0;
         beeps    <= '0;
         aborted  <= 1'b0;
         o_buzzer <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         state    <= state_d;
         pending  <= pending_d;
         grant    <= grant_d;
         beeps    <= beeps_d;
         aborted  <= aborted_d;
         o_buzzer <= (state_d == ST_ON) && !i_mute;
         o_busy   <= (state_d != ST_IDLE);
         o_done   <= (state_d == ST_GAP) && (timer_next == '0) && !aborted_d;
      end
   end

   assign o_grant = grant;

endmodule
`default_nettype wire

// File: tb/tb_pmod_alert_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pmod_alert_scheduler                                      |
// | Description : Self-checking bench for pmod_alert_scheduler. A pattern-     |
// |               offset reference model predicts every output each cycle.     |
// |               Honours ALERT_PREEMPT_EN when defined.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pmod_alert_scheduler;

   localparam int N_REQ = 3;
   localparam int TON   = 4;
   localparam int TOFF  = 3;
   localparam int TGAP  = 5;
`ifdef ALERT_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic             i_clock = 1'b0;
   logic             i_reset;
   logic [N_REQ-1:0] i_req;
   logic             i_mute;
   logic             o_buzzer;
   logic             o_busy;
   logic [N_REQ-1:0] o_grant;
   logic             o_done;

   pmod_alert_scheduler #(
      .N_REQ     (N_REQ),
      .TICKS_ON  (TON),
      .TICKS_OFF (TOFF),
      .TICKS_GAP (TGAP)
   ) dut (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_req    (i_req),
      .i_mute   (i_mute),
      .o_buzzer (o_buzzer),
      .o_busy   (o_busy),
      .o_grant  (o_grant),
      .o_done   (o_done)
   );

   always #5 i_clock = ~i_clock;

   int compared   = 0;
   int mismatched = 0;
   int buz_high   = 0;
   int done_cnt   = 0;

   // Reference model: a pattern is a time line indexed by offset m_o.
   bit               m_active = 1'b0;
   bit               m_aborted = 1'b0;
   int               m_k = 0;
   int               m_o = 0;
   bit [N_REQ-1:0]   m_pend = '0;
   bit               e_buz, e_busy, e_done;
   bit [N_REQ-1:0]   e_grant;

   task automatic check_value(input string tag, input int unsigned got, input int unsigned exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sound_len(input int k);
      return (k + 1) * TON + k * TOFF;
   endfunction

   function automatic int pat_len(input int k);
      return sound_len(k) + TGAP;
   endfunction

   task automatic model_step(input bit rst, input bit [N_REQ-1:0] req, input bit mute);
      bit [N_REQ-1:0] cand;
      if (rst) begin
         m_active  = 1'b0;
         m_aborted = 1'b0;
         m_pend    = '0;
         m_o       = 0;
         m_k       = 0;
      end else begin
         cand   = m_pend | req;
         m_pend = cand;
         if (!m_active) begin
            if (cand != '0) begin
               for (int i = 0; i < N_REQ; i++) begin
                  if (cand[i]) m_k = i;
               end
               m_pend    = m_pend & ~(N_REQ'(1) << m_k);
               m_active  = 1'b1;
               m_aborted = 1'b0;
               m_o       = 0;
            end
         end else if (PREEMPT && m_o < sound_len(m_k) && (cand >> (m_k + 1)) != '0) begin
            m_o       = sound_len(m_k);
            m_aborted = 1'b1;
         end else if (m_o == pat_len(m_k) - 1) begin
            m_active = 1'b0;
         end else begin
            m_o++;
         end
      end
      if (m_active) begin
         e_busy  = 1'b1;
         e_grant = N_REQ'(1) << m_k;
         e_buz   = !mute && (m_o < sound_len(m_k)) && ((m_o % (TON + TOFF)) < TON);
         e_done  = (m_o == pat_len(m_k) - 1) && !m_aborted;
      end else begin
         e_busy  = 1'b0;
         e_grant = '0;
         e_buz   = 1'b0;
         e_done  = 1'b0;
      end
   endtask

   task automatic tick(input bit rst, input bit [N_REQ-1:0] req, input bit mute);
      @(negedge i_clock);
      i_reset = rst;
      i_req   = req;
      i_mute  = mute;
      @(posedge i_clock);
      model_step(rst, req, mute);
      #1;
      check_value("buzzer", o_buzzer, e_buz);
      check_value("busy",   o_busy,   e_busy);
      check_value("grant",  o_grant,  e_grant);
      check_value("done",   o_done,   e_done);
      if (o_buzzer) buz_high++;
      if (o_done)   done_cnt++;
   endtask

   task automatic idle(input int n, input bit mute);
      for (int i = 0; i < n; i++) tick(1'b0, '0, mute);
   endtask

   initial begin
      i_reset = 1'b1;
      i_req   = '0;
      i_mute  = 1'b0;

      // Reset with all requests asserted: nothing may play afterwards.
      tick(1'b1, 3'b111, 1'b0);
      tick(1'b1, 3'b111, 1'b0);
      buz_high = 0; done_cnt = 0;
      idle(6, 1'b0);
      check_value("post_reset_quiet", buz_high + done_cnt, 0);

      // Single beep for requester 0.
      buz_high = 0; done_cnt = 0;
      tick(1'b0, 3'b001, 1'b0);
      idle(12, 1'b0);
      check_value("req0_high_cycles", buz_high, TON);
      check_value("req0_done_count", done_cnt, 1);

      // Three beeps for requester 2.
      buz_high = 0; done_cnt = 0;
      tick(1'b0, 3'b100, 1'b0);
      idle(26, 1'b0);
      check_value("req2_high_cycles", buz_high, 3 * TON);
      check_value("req2_done_count", done_cnt, 1);

      // Two simultaneous requests: 2 beeps for req1, then 1 beep for req0.
      buz_high = 0; done_cnt = 0;
      tick(1'b0, 3'b011, 1'b0);
      idle(40, 1'b0);
      check_value("dual_high_cycles", buz_high, 3 * TON);
      check_value("dual_done_count", done_cnt, 2);

      // Muted pattern: silent, sequencing unchanged.
      buz_high = 0; done_cnt = 0;
      tick(1'b0, 3'b100, 1'b1);
      idle(26, 1'b1);
      check_value("mute_high_cycles", buz_high, 0);
      check_value("mute_done_count", done_cnt, 1);

      // Higher request during the second ON cycle of requester 0.
      buz_high = 0; done_cnt = 0;
      tick(1'b0, 3'b001, 1'b0);
      tick(1'b0, 3'b000, 1'b0);
      tick(1'b0, 3'b100, 1'b0);
      idle(45, 1'b0);
      check_value("preempt_done_count", done_cnt, PREEMPT ? 1 : 2);
      check_value("preempt_high_cycles", buz_high, PREEMPT ? 2 + 3 * TON : 4 * TON);

      // Reset mid-pattern with a request pending.
      tick(1'b0, 3'b010, 1'b0);
      idle(3, 1'b0);
      tick(1'b0, 3'b001, 1'b0);
      tick(1'b1, 3'b000, 1'b0);
      buz_high = 0; done_cnt = 0;
      idle(20, 1'b0);
      check_value("reset_clears_pending", buz_high + done_cnt, 0);

      // Randomized traffic with occasional mute and reset.
      for (int i = 0; i < 500; i++) begin
         bit [N_REQ-1:0] r;
         r = ($urandom_range(0, 11) == 0) ? N_REQ'($urandom_range(1, 7)) : '0;
         tick($urandom_range(0, 249) == 0, r, $urandom_range(0, 7) == 0);
      end
      idle(30, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
